// File: rtl/button_press_handler.sv
// Turns a synchronized pushbutton level into one step per press plus hold-to-repeat steps, with release and long-press status.
// All outputs registered: step one clk after the first pressed cycle; no backpressure, pulses are fire-and-forget.
module button_press_handler #(
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int CNT_W        = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_en,
  input  logic repeat_en,
  input  logic btn_sync,
  output logic step,
  output logic release_pulse,
  output logic long_press
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_REPEAT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             step_q, step_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             rise;

  assign rise = btn_sync & ~btn_q;

  // State register. btn_q clearing on reset makes a still-held button re-fire after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      step_q  <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_sync;
      step_q  <= step_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  // Next-state logic. Release is tested first so it beats a coincident counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_PRESSED;
          step_d  = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn_sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else if (!repeat_en) begin
          cnt_d = '0;
        end else if (tick_en) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_REPEAT;
            cnt_d   = '0;
            step_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_REPEAT: begin
        if (!btn_sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else if (!repeat_en) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (tick_en) begin
          if (cnt_q == REPEAT_LAST) begin
            cnt_d  = '0;
            step_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: long_press follows the registered state, so it lags REPEAT entry/exit by one clk.
  always_comb begin
    long_d        = (state_q == ST_REPEAT);
    step          = step_q;
    release_pulse = rel_q;
    long_press    = long_q;
  end

endmodule

// File: tb/tb_button_press_handler.sv
// Directed bench for button_press_handler with HOLD_TICKS=5, REPEAT_TICKS=2 and tick_en every 4th clk.
module tb_button_press_handler;

  logic clk = 1'b0;
  logic rst;
  logic tick_en;
  logic repeat_en;
  logic btn_sync;
  logic step;
  logic release_pulse;
  logic long_press;

  int n_tests = 0;
  int n_fail  = 0;
  int e;
  int step_log[$];
  int rel_log[$];
  int exp_q[$];
  int long_first;
  int long_last;
  int long_cnt;
  int overlap = 0;

  button_press_handler #(
    .HOLD_TICKS  (5),
    .REPEAT_TICKS(2),
    .CNT_W       (4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .tick_en      (tick_en),
    .repeat_en    (repeat_en),
    .btn_sync     (btn_sync),
    .step         (step),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  task automatic chk_log(input string tag, input int got[$], input int expv[$]);
    chk({tag, "_count"}, got.size(), expv.size());
    for (int i = 0; i < expv.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, expv[i]);
  endtask

  task automatic clear_logs();
    step_log.delete();
    rel_log.delete();
    long_first = -1;
    long_last  = -1;
    long_cnt   = 0;
    e          = 0;
  endtask

  // Drive n clocks with fixed button/enable levels; outputs are logged by clock index #1 after each edge.
  task automatic run(input int n, input logic b, input logic r);
    for (int i = 0; i < n; i++) begin
      btn_sync  = b;
      repeat_en = r;
      tick_en   = (e % 4 == 3);
      @(posedge clk);
      #1;
      if (step) step_log.push_back(e);
      if (release_pulse) rel_log.push_back(e);
      if (step && release_pulse) overlap++;
      if (long_press) begin
        if (long_cnt == 0) long_first = e;
        long_last = e;
        long_cnt++;
      end
      e++;
    end
    tick_en = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    tick_en   = 1'b0;
    repeat_en = 1'b1;
    btn_sync  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_step", int'(step), 0);
    chk("rst_release", int'(release_pulse), 0);
    chk("rst_long", int'(long_press), 0);
    rst = 1'b0;

    // Idle with button up: nothing fires
    clear_logs();
    run(6, 1'b0, 1'b1);
    chk("idle_steps", step_log.size(), 0);
    chk("idle_releases", rel_log.size(), 0);

    // Short press
    clear_logs();
    run(10, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);
    exp_q = '{0};
    chk_log("short_step", step_log, exp_q);
    exp_q = '{10};
    chk_log("short_rel", rel_log, exp_q);
    chk("short_long_cnt", long_cnt, 0);

    // Long hold with auto-repeat
    clear_logs();
    run(60, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);
    exp_q = '{0, 19, 27, 35, 43, 51, 59};
    chk_log("long_step", step_log, exp_q);
    exp_q = '{60};
    chk_log("long_rel", rel_log, exp_q);
    chk("long_first", long_first, 20);
    chk("long_last", long_last, 60);
    chk("long_cnt", long_cnt, 41);

    // Hold with repeat disabled, then enable mid-hold
    clear_logs();
    run(60, 1'b1, 1'b0);
    run(36, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);
    exp_q = '{0, 79, 87, 95};
    chk_log("ren_step", step_log, exp_q);
    exp_q = '{96};
    chk_log("ren_rel", rel_log, exp_q);
    chk("ren_long_first", long_first, 80);
    chk("ren_long_last", long_last, 96);

    // Release on the tick that would expire the hold, then a fresh press
    clear_logs();
    run(19, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);
    run(4, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);
    exp_q = '{0, 24};
    chk_log("race_step", step_log, exp_q);
    exp_q = '{19, 28};
    chk_log("race_rel", rel_log, exp_q);
    chk("race_long_cnt", long_cnt, 0);

    // Reset mid-REPEAT with button held
    clear_logs();
    run(25, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_step", int'(step), 0);
    chk("midrst_release", int'(release_pulse), 0);
    chk("midrst_long", int'(long_press), 0);
    run(3, 1'b1, 1'b1);
    rst = 1'b0;
    run(23, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);
    exp_q = '{0, 19, 28, 47};
    chk_log("midrst_steps", step_log, exp_q);
    exp_q = '{51};
    chk_log("midrst_rel", rel_log, exp_q);
    chk("midrst_long_cnt", long_cnt, 9);

    // One-clock release then re-press
    clear_logs();
    run(10, 1'b1, 1'b1);
    run(1, 1'b0, 1'b1);
    run(10, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);
    exp_q = '{0, 11};
    chk_log("repress_step", step_log, exp_q);
    exp_q = '{10, 21};
    chk_log("repress_rel", rel_log, exp_q);
    chk("repress_long_cnt", long_cnt, 0);

    chk("step_rel_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_press_handler.md
Name: button_press_handler

Overview:
- Sits directly downstream of the pushbutton synchronizer. Consumes its clean, clock-aligned level (btn_sync).
- Produces one-cycle "step" pulses for the time/alarm adjust logic:
  - one step on the press;
  - after a hold delay, repeating steps at a fixed rate while the button stays down (hold-to-fast-adjust).
- Also reports release and long-press status.
- One instance per adjust pushbutton.

Parameters:
- HOLD_TICKS, 500, tick_en pulses the button must stay pressed before auto-repeat starts (500 ms at 1 kHz tick); legal range ≥1.
- REPEAT_TICKS, 100, tick_en pulses between auto-repeat steps (100 ms at 1 kHz tick); legal range ≥1.
- CNT_W, 10, tick counter width; must satisfy 2^CNT_W > max(HOLD_TICKS, REPEAT_TICKS).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick_en  in  1  one-clk-wide timebase strobe (e.g. 1 kHz from the clock divider)
- repeat_en  in  1  1 = auto-repeat allowed; 0 = press gives a single step only
- btn_sync  in  1  synchronized button level, 1 = pressed
- step  out  1  one-cycle pulse per press and per auto-repeat event
- release_pulse  out  1  one-cycle pulse when the button is released
- long_press  out  1  level, high while in auto-repeat state

Behaviour:
- Reset: rst=1 asynchronously forces state=IDLE, counter=0, btn_q=0, step=0, release_pulse=0, long_press=0.
- Edge detect: btn_q <= btn_sync every clk.
  - rise = btn_sync & ~btn_q.
  - All outputs are registered.
- FSM states: IDLE, PRESSED, REPEAT.
- IDLE:
  - On rise: go to PRESSED, counter <= 0, step=1 in the next cycle. Latency is 1 clk from the first cycle btn_sync=1.
  - tick_en is ignored.
- PRESSED:
  - btn_sync=0: go to IDLE, counter <= 0, release_pulse=1 next cycle.
  - Else if repeat_en=0: hold; counter stays 0.
  - Else on tick_en:
    - counter==HOLD_TICKS-1: go to REPEAT, counter <= 0, step=1 next cycle.
    - Otherwise counter+1.
- REPEAT:
  - long_press=1 while in this state (registered; asserts the cycle after entry, deasserts the cycle after exit).
  - btn_sync=0: go to IDLE, counter <= 0, release_pulse=1.
  - Else if repeat_en=0: go to PRESSED, counter <= 0, no step.
  - Else on tick_en:
    - counter==REPEAT_TICKS-1: step=1, counter <= 0.
    - Otherwise counter+1.
- Steps-per-hold timing: the first repeat step fires on the HOLD_TICKS-th tick after the press cycle. Each later step fires every REPEAT_TICKS ticks.
- A tick_en in the same cycle as rise is not counted. Counting starts with the next tick.
- Simultaneous events:
  - Release in the same cycle as counter expiry: release wins, no step, release_pulse=1.
  - A new rise is only possible from IDLE. A 1-cycle release then re-press yields release_pulse, then step (2 cycles later).
- step and release_pulse are never high in the same cycle. Each is high for exactly 1 clk per event.
- Counter never exceeds max(HOLD_TICKS, REPEAT_TICKS)-1. No wrap-around is possible under legal parameters.
- Reset mid-press:
  - Outputs clear immediately.
  - After rst falls with btn_sync still 1, btn_q=0 yields a rise and one new step. This is intentional.

Test Plan:
(HOLD_TICKS=5, REPEAT_TICKS=2, tick_en every 4th clk)
- Short press: btn_sync high for 10 clk, repeat_en=1.
  - Required: exactly one step, 1 clk after the rise.
  - Required: release_pulse 1 clk after the fall.
  - Required: long_press stays 0.
- Long hold: btn_sync high for 60 clk.
  - Required: step at press; then step on the 5th tick; then on every 2nd tick.
  - Required: long_press high from the cycle after the first repeat step until the cycle after release.
- repeat_en=0 hold for 60 clk:
  - Required: single step only; long_press=0.
  - Then raise repeat_en mid-hold: the first repeat step comes 5 ticks later.
- Release coinciding with the tick that would expire HOLD_TICKS:
  - Required: no step; release_pulse=1; state returns to IDLE.
- Reset pulse mid-REPEAT with button still held:
  - Required: all outputs 0 during rst.
  - Required: one step 1–2 clk after rst deasserts; hold timing restarts from counter 0.
- Chatter-free rapid re-press: low 1 clk, high again.
  - Required: release_pulse, then a new step.
  - Required: no missed or duplicate pulses.
